branch_update_unit: RTL

Sits between ROB commit and the branch predictor's update side, upstream of the predictor's write port. It queues resolved conditional branches (address and actual outcome) in a small FIFO. For each queued branch it reads the current 2-bit counter through the predictor's ROB read port, computes the saturated next counter value, and issues one write strobe to the predictor. It also keeps update and mispredict statistics for performance counters.

---
 rtl/branch_update_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/branch_update_unit.sv
// Queues resolved conditional branches and replays each one into the branch predictor as a
// read-modify-write of its 2-bit saturating counter, keeping update/mispredict statistics.
module branch_update_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     resolveValid,
  output logic                     resolveReady,
  input  logic [31:0]              resolveAddr,
  input  logic                     resolveTaken,
  output logic [31:0]              predROBReadAddr,
  input  logic [1:0]               predROBCounter,
  output logic                     predWriteEnable,
  output logic [31:0]              predWriteAddr,
  output logic [1:0]               predWriteData,
  output logic [$clog2(DEPTH):0]   fifoCount,
  output logic                     busy,
  output logic [CNT_W-1:0]         updateCount,
  output logic [CNT_W-1:0]         mispredictCount
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] Full = (PtrW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StGap} state_e;

  state_e              state_q;
  logic [31:0]         addr_q [DEPTH];
  logic [DEPTH-1:0]    taken_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       count_q;
  logic [31:0]         rd_addr_q, wr_addr_q;
  logic                wr_en_q;
  logic [1:0]          wr_data_q;
  logic [CNT_W-1:0]    upd_q, misp_q;

  logic                push, pop;
  logic [31:0]         head_addr;
  logic                head_taken;
  logic [1:0]          next_cnt;

  // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign resolveReady = rst_n && (count_q < Full);
  assign push         = resolveValid && resolveReady;
  assign pop          = (state_q == StWrite);
  assign head_addr    = addr_q[rd_ptr_q];
  assign head_taken   = taken_q[rd_ptr_q];

  always_comb begin
    next_cnt = predROBCounter;
    if (head_taken) begin
      next_cnt = (predROBCounter == 2'b11) ? 2'b11 : predROBCounter + 2'b01;
    end else begin
      next_cnt = (predROBCounter == 2'b00) ? 2'b00 : predROBCounter - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q]  <= resolveAddr;
      taken_q[wr_ptr_q] <= resolveTaken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      upd_q     <= '0;
      misp_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            state_q   <= StRead;
            rd_addr_q <= head_addr;
          end
        end
        StRead: begin
          wr_addr_q <= head_addr;
          wr_data_q <= next_cnt;
          if (predROBCounter[1] != head_taken) misp_q <= misp_q + CNT_W'(1);
          wr_en_q   <= 1'b1;
          state_q   <= StWrite;
        end
        StWrite: begin
          upd_q   <= upd_q + CNT_W'(1);
          state_q <= StGap;
        end
        StGap: begin
          // Head already advanced by the pop, so this read sees the post-write table.
          if (count_q != '0) begin
            state_q   <= StRead;
            rd_addr_q <= head_addr;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign predROBReadAddr = rd_addr_q;
  assign predWriteEnable = wr_en_q;
  assign predWriteAddr   = wr_addr_q;
  assign predWriteData   = wr_data_q;
  assign fifoCount       = count_q;
  assign busy            = (count_q != '0) || (state_q != StIdle);
  assign updateCount     = upd_q;
  assign mispredictCount = misp_q;

endmodule
